// File: rtl/mfe_led7seg_bin2seg.sv
// Binary-to-7-segment frame builder: serial double-dabble BCD
// conversion, one bit per clock, then active-low segment encoding.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   bin      in   BIN_WIDTH  unsigned value to display
//   dp       in   DIG_NUM    decimal point per digit (1 = lit)
//   bin_vld  in   bin/dp valid
//   bin_rdy  out  idle, can accept a new value
//   dat      out  DIG_NUM*SEG_NUM frame, digit i in dat[8i+7:8i]
//   vld      out  1-cycle pulse, dat updated this cycle
//   ovf      out  last frame did not fit in DIG_NUM digits
//
// Build option MFE_LED7SEG_LZB_EN: leading-zero blanking.

module mfe_led7seg_bin2seg #(
    parameter int DIG_NUM   = 8,
    parameter int SEG_NUM   = 8,
    parameter int BIN_WIDTH = 27
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BIN_WIDTH-1:0]       bin,
    input  logic [DIG_NUM-1:0]         dp,
    input  logic                       bin_vld,
    output logic                       bin_rdy,
    output logic [DIG_NUM*SEG_NUM-1:0] dat,
    output logic                       vld,
    output logic                       ovf
);

    // Three spare nibbles above the displayed digits catch values
    // that do not fit; r_lost covers anything shifted past them.
    localparam int NIB_NUM = DIG_NUM + 3;
    localparam int BCD_W   = 4 * NIB_NUM;
    localparam int FRM_W   = DIG_NUM * SEG_NUM;
    localparam int CNT_W   = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_WIDTH - 1);

    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_ENC,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [CNT_W-1:0]     r_cnt;
    logic [BIN_WIDTH-1:0] r_bin_sh;
    logic [BCD_W-1:0]     r_bcd;
    logic                 r_lost;
    logic [DIG_NUM-1:0]   r_dp;

    logic [FRM_W-1:0]     r_seg;
    logic                 r_seg_ovf;

    logic [FRM_W-1:0]     r_dat;
    logic                 r_vld;
    logic                 r_ovf;

    logic                 w_accept;
    logic                 w_last;
    logic [BCD_W-1:0]     w_bcd_adj;
    logic                 w_ovf;
    logic [FRM_W-1:0]     w_frame;
    logic [7:0]           w_dig;
`ifdef MFE_LED7SEG_LZB_EN
    logic                 w_seen;
`endif

    // Active-low a..g code, bit7 (dp) left dark.
    function automatic logic [7:0] f_seg(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    assign bin_rdy = (r_state == S_IDLE);
    assign dat     = r_dat;
    assign vld     = r_vld;
    assign ovf     = r_ovf;

    // ---------------------------------------------------------
    // FSM
    // ---------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bin_vld) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CONV;
                end
            end
            S_CONV: begin
                if (r_cnt == CNT_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_ENC;
                end
            end
            S_ENC: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------
    // Double-dabble correction: +3 on every nibble >= 5
    // ---------------------------------------------------------
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < NIB_NUM; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // ---------------------------------------------------------
    // Overflow and segment frame
    // ---------------------------------------------------------
    assign w_ovf = r_lost | (|r_bcd[BCD_W-1:4*DIG_NUM]);

    always_comb begin
        w_frame = '1;
        w_dig   = SEG_BLANK;
`ifdef MFE_LED7SEG_LZB_EN
        w_seen  = 1'b0;
`endif
        // Walk from the top digit down so blanking knows whether
        // a nonzero digit has been seen above the current one.
        for (int i = DIG_NUM - 1; i >= 0; i--) begin
`ifdef MFE_LED7SEG_LZB_EN
            w_seen = w_seen | (r_bcd[4*i +: 4] != 4'd0);
`endif
            if (w_ovf) begin
                w_dig = SEG_DASH;
            end else begin
`ifdef MFE_LED7SEG_LZB_EN
                if (!w_seen && (i != 0)) begin
                    w_dig = r_dp[i] ? 8'h7F : SEG_BLANK;
                end else begin
                    w_dig = f_seg(r_bcd[4*i +: 4]) & {~r_dp[i], 7'h7F};
                end
`else
                w_dig = f_seg(r_bcd[4*i +: 4]) & {~r_dp[i], 7'h7F};
`endif
            end
            w_frame[SEG_NUM*i +: SEG_NUM] = w_dig;
        end
    end

    // ---------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_bin_sh  <= '0;
            r_bcd     <= '0;
            r_lost    <= 1'b0;
            r_dp      <= '0;
            r_seg     <= '1;
            r_seg_ovf <= 1'b0;
            r_dat     <= '1;
            r_vld     <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_bin_sh <= bin;
                        r_dp     <= dp;
                        r_bcd    <= '0;
                        r_cnt    <= '0;
                        r_lost   <= 1'b0;
                    end
                end
                S_CONV: begin
                    r_bcd    <= {w_bcd_adj[BCD_W-2:0],
                                 r_bin_sh[BIN_WIDTH-1]};
                    r_bin_sh <= {r_bin_sh[BIN_WIDTH-2:0], 1'b0};
                    r_lost   <= r_lost | w_bcd_adj[BCD_W-1];
                    // Counter parks on the last value.
                    if (!w_last) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_ENC: begin
                    r_seg     <= w_frame;
                    r_seg_ovf <= w_ovf;
                end
                S_DONE: begin
                    r_dat <= r_seg;
                    r_ovf <= r_seg_ovf;
                    r_vld <= 1'b1;
                end
                default: begin
                    r_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule
